filter_reduce_unit_mn: RTL and testbench

//  Next-gen filter/reduce stage of the trace pipeline. Each input vector (N lanes) is expanded

---
 rtl/filter_reduce_unit_mn.sv | 199 +++++++++++++++++++
 tb/tb_filter_reduce_unit_mn.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/filter_reduce_unit_mn.sv
// filter_reduce_unit_mn
//   Trace-pipeline filter/reduce stage. Each accepted N-lane vector is
//   compared lane-by-lane against M thresholds taken from a local FUVRF entry.
//   The comparison results form an MxN filter matrix. That matrix is then
//   reduced along N (per-row sums) or along M (per-lane sums), or passed
//   through. The per-chain firmware registers (op, FUVRF addr, axis) can be
//   rewritten one byte per cycle over the config bus.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   tracing             gates acceptance of valid_in
//   valid_in/eof_in/chainId_in/vector_in   input vector and sideband
//   configId/configData byte-serial firmware write bus
//   fuvrf_we/fuvrf_addr/fuvrf_data         threshold file write port
//   vector_out/chainId_out/valid_out/eof_out  results, latency 2 after accept

// One lane: builds filter column F[*][n] (registered) and its sum over M.
module filter_reduce_lane #(
  parameter int M  = 4,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DW-1:0]        x,
  input  logic [M-1:0][DW-1:0] thr,
  input  logic [7:0]           op,
  output logic [M-1:0][DW-1:0] col_q,
  output logic [DW-1:0]        col_sum
);
  logic [M-1:0][DW-1:0] col_d;

  always_comb begin
    col_d = '0;
    for (int m = 0; m < M; m++) begin
      case (op)
        8'd1:    col_d[m] = ($signed(x) < $signed(thr[m])) ? x : '0;
        8'd2:    col_d[m] = ($signed(x) < $signed(thr[m])) ? DW'(1) : '0;
        default: col_d[m] = x;   // PASS, and any unknown op
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) col_q <= '0;
    else       col_q <= col_d;
  end

  // Wraps modulo 2^DW.
  always_comb begin
    col_sum = '0;
    for (int m = 0; m < M; m++) col_sum = col_sum + col_q[m];
  end
endmodule

module filter_reduce_unit_mn #(
  parameter int N                  = 8,
  parameter int M                  = 4,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 1,
  parameter int FUVRF_SIZE         = 4,
  // per-chain reset values, element c belongs to chain c
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_FILTER_OP   = '0,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_FILTER_ADDR = '0,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_REDUCE_AXIS = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 tracing,
  input  logic                                 valid_in,
  input  logic                                 eof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0]        chainId_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]         vector_in,
  input  logic [7:0]                           configId,
  input  logic [7:0]                           configData,
  input  logic                                 fuvrf_we,
  input  logic [$clog2(FUVRF_SIZE)-1:0]        fuvrf_addr,
  input  logic [M-1:0][DATA_WIDTH-1:0]         fuvrf_data,
  output logic [N-1:0][DATA_WIDTH-1:0]         vector_out,
  output logic [$clog2(MAX_CHAINS)-1:0]        chainId_out,
  output logic                                 valid_out,
  output logic                                 eof_out
);
  localparam int DW     = DATA_WIDTH;
  localparam int CW     = $clog2(MAX_CHAINS);
  localparam int AW     = $clog2(FUVRF_SIZE);
  localparam int SLOTS  = 3 * MAX_CHAINS;
  localparam int PW     = $clog2(SLOTS);
  localparam int STAGES = 2;

  // Firmware byte slots: chain c -> {op, addr, axis} at 3c, 3c+1, 3c+2.
  logic [SLOTS-1:0][7:0]                 fw;
  logic [PW-1:0]                         cfg_ptr;
  logic [FUVRF_SIZE-1:0][M-1:0][DW-1:0]  fuvrf;

  logic                                  acc;
  logic [PW-1:0]                         op_idx, addr_idx, axis_idx;
  logic [AW-1:0]                         rd_addr;

  logic [STAGES:0]                       vld_pipe, eof_pipe;
  logic [N-1:0][DW-1:0]                  s1_vec;
  logic [CW-1:0]                         s1_chain, s2_chain;
  logic [7:0]                            s1_op, s1_axis, s2_axis;
  logic [M-1:0][DW-1:0]                  s1_thr;
  logic [N-1:0][M-1:0][DW-1:0]           f;
  logic [N-1:0][DW-1:0]                  col_sum, red;

  assign acc      = valid_in & tracing;
  assign op_idx   = PW'(3 * int'(chainId_in));
  assign addr_idx = op_idx + PW'(1);
  assign axis_idx = op_idx + PW'(2);
  // Out-of-range addresses fold back into the file.
  assign rd_addr  = AW'(32'(fw[addr_idx]) % FUVRF_SIZE);

  // Firmware, config pointer and threshold file. Reads in stage 1 see the
  // pre-edge contents, so same-cycle writes only affect later accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        fw[PW'(3*c)]   <= INITIAL_FIRMWARE_FILTER_OP[c];
        fw[PW'(3*c+1)] <= INITIAL_FIRMWARE_FILTER_ADDR[c];
        fw[PW'(3*c+2)] <= INITIAL_FIRMWARE_REDUCE_AXIS[c];
      end
      cfg_ptr <= '0;
      fuvrf   <= '0;
    end else begin
      if (configId == 8'(PERSONAL_CONFIG_ID)) begin
        fw[cfg_ptr] <= configData;
        cfg_ptr     <= (cfg_ptr == PW'(SLOTS-1)) ? '0 : cfg_ptr + 1'b1;
      end
      if (fuvrf_we) fuvrf[fuvrf_addr] <= fuvrf_data;
    end
  end

  // Stage 1 captures only on accept; bubbles leave the data regs untouched
  // so the result lanes stay quiet while nothing is flowing.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      eof_pipe <= '0;
      s1_vec   <= '0;
      s1_chain <= '0;
      s1_op    <= '0;
      s1_axis  <= '0;
      s1_thr   <= '0;
      s2_chain <= '0;
      s2_axis  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], acc};
      eof_pipe <= {eof_pipe[STAGES-1:0], acc & eof_in};
      if (acc) begin
        s1_vec   <= vector_in;
        s1_chain <= chainId_in;
        s1_op    <= fw[op_idx];
        s1_axis  <= fw[axis_idx];
        s1_thr   <= fuvrf[rd_addr];
      end
      s2_chain <= s1_chain;
      s2_axis  <= s1_axis;
    end
  end

  // Stage 2: filter matrix, one column per lane.
  for (genvar n = 0; n < N; n++) begin : g_lane
    filter_reduce_lane #(.M(M), .DW(DW)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .x      (s1_vec[n]),
      .thr    (s1_thr),
      .op     (s1_op),
      .col_q  (f[n]),
      .col_sum(col_sum[n])
    );
  end

  always_comb begin
    red = '0;
    case (s2_axis)
      8'd1: begin   // along N: row sums land in lanes 0..M-1
        for (int m = 0; m < M; m++)
          for (int n = 0; n < N; n++) red[m] = red[m] + f[n][m];
      end
      8'd2:    red = col_sum;   // along M
      default: for (int n = 0; n < N; n++) red[n] = f[n][0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vector_out  <= '0;
      chainId_out <= '0;
    end else begin
      vector_out  <= red;
      chainId_out <= s2_chain;
    end
  end

  assign valid_out = vld_pipe[STAGES];
  assign eof_out   = eof_pipe[STAGES];
endmodule

// File: tb/tb_filter_reduce_unit_mn.sv
module tb_filter_reduce_unit_mn;
  localparam int N = 8, M = 4, DW = 32;
  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef logic [M-1:0][DW-1:0] thr_t;
  typedef struct packed {
    logic       vld;
    logic       eof;
    logic       zchk;   // output must be all-zero (just after reset)
    logic [1:0] chain;
    vec_t       vec;
  } ent_t;

  logic clk = 0, reset, tracing, valid_in, eof_in, fuvrf_we, valid_out, eof_out;
  logic [1:0] chainId_in, fuvrf_addr, chainId_out;
  vec_t vector_in, vector_out;
  logic [7:0] configId, configData;
  thr_t fuvrf_data;

  int n_cmp = 0, n_err = 0;
  ent_t q[$];
  ent_t mon_e;

  // bench-side firmware / threshold model
  logic [11:0][7:0] mfw;
  int               mptr;
  thr_t             mfu [4];

  logic [7:0] bytes_a [6] = '{0, 0, 0, 1, 1, 1};
  logic [7:0] bytes_b [6] = '{2, 1, 2, 2, 1, 1};
  logic [7:0] bytes_c [9] = '{1, 1, 1, 2, 1, 2, 2, 1, 1};

  always #5 clk = ~clk;

  filter_reduce_unit_mn dut (
    .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .chainId_in(chainId_in), .vector_in(vector_in),
    .configId(configId), .configData(configData), .fuvrf_we(fuvrf_we),
    .fuvrf_addr(fuvrf_addr), .fuvrf_data(fuvrf_data), .vector_out(vector_out),
    .chainId_out(chainId_out), .valid_out(valid_out), .eof_out(eof_out)
  );

  function automatic vec_t seq(input int base);
    vec_t v;
    for (int n = 0; n < N; n++) v[n] = 32'(base + n);
    return v;
  endfunction

  // Reference: build F[m][n] from the op rules, then reduce by axis.
  function automatic vec_t model(input vec_t x, input thr_t t, input logic [7:0] op,
                                 input logic [7:0] ax);
    logic [M-1:0][N-1:0][DW-1:0] fm;
    vec_t r;
    logic lt;
    r = '0;
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) begin
        lt = $signed(x[n]) < $signed(t[m]);
        if (op == 1)      fm[m][n] = lt ? x[n] : 32'd0;
        else if (op == 2) fm[m][n] = lt ? 32'd1 : 32'd0;
        else              fm[m][n] = x[n];
      end
    if (ax == 1) begin
      for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) r[m] = r[m] + fm[m][n];
    end else if (ax == 2) begin
      for (int n = 0; n < N; n++) for (int m = 0; m < M; m++) r[n] = r[n] + fm[m][n];
    end else begin
      for (int n = 0; n < N; n++) r[n] = fm[0][n];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: entry pushed at edge k is due after edge k+2.
  always @(negedge clk) begin
    if (q.size() >= 3) begin
      mon_e = q.pop_front();
      chk("valid_out", N*DW'(valid_out), N*DW'(mon_e.vld));
      chk("eof_out", N*DW'(eof_out), N*DW'(mon_e.eof));
      if (mon_e.vld) begin
        chk("vector_out", vector_out, mon_e.vec);
        chk("chainId_out", N*DW'(chainId_out), N*DW'(mon_e.chain));
      end
      if (mon_e.zchk) begin
        chk("reset_vector_out", vector_out, '0);
        chk("reset_chainId_out", N*DW'(chainId_out), '0);
      end
    end
  end

  // One clock: sample at posedge, record expectation with pre-edge firmware,
  // then apply the model's config / FUVRF writes and clear one-shot inputs.
  task automatic tick();
    ent_t e;
    int   b;
    @(posedge clk);
    if (reset) begin
      q.delete();
      e = '0;
      e.zchk = 1'b1;
      repeat (3) q.push_back(e);
      mfw  = '0;
      mptr = 0;
      for (int i = 0; i < 4; i++) mfu[i] = '0;
    end else begin
      e       = '0;
      e.vld   = valid_in & tracing;
      e.eof   = valid_in & tracing & eof_in;
      e.chain = chainId_in;
      b       = 3 * int'(chainId_in);
      if (e.vld) e.vec = model(vector_in, mfu[int'(mfw[b+1]) % 4], mfw[b], mfw[b+2]);
      q.push_back(e);
      if (configId == 8'd1) begin
        mfw[mptr] = configData;
        mptr = (mptr == 11) ? 0 : mptr + 1;
      end
      if (fuvrf_we) mfu[fuvrf_addr] = fuvrf_data;
    end
    #1;
    valid_in = 0; eof_in = 0; configId = 0; fuvrf_we = 0; reset = 0;
  endtask

  task automatic send(input logic [7:0] id, input logic [7:0] d);
    configId = id; configData = d; tick();
  endtask

  task automatic vec(input logic [1:0] c, input vec_t x, input logic eof);
    valid_in = 1; chainId_in = c; vector_in = x; eof_in = eof; tick();
  endtask

  initial begin
    reset = 1; tracing = 1; valid_in = 0; eof_in = 0; chainId_in = 0; vector_in = '0;
    configId = 0; configData = 0; fuvrf_we = 0; fuvrf_addr = 0; fuvrf_data = '0;
    mfw = '0; mptr = 0;
    reset = 1; tick();
    reset = 1; tick();

    // defaults: pass-through
    vec(2'd0, seq(1), 1'b1);
    tick(); tick();

    // FUVRF[1] = {3,5,7,9}; chain1 = MASK, addr1, ALONG_N
    fuvrf_we = 1; fuvrf_addr = 1; fuvrf_data = {32'd9, 32'd7, 32'd5, 32'd3}; tick();
    foreach (bytes_a[i]) send(8'd1, bytes_a[i]);
    vec(2'd1, seq(1), 1'b0);

    // chain2 COUNT/ALONG_M, chain3 COUNT/ALONG_N; pointer wraps afterwards
    foreach (bytes_b[i]) send(8'd1, bytes_b[i]);
    vec(2'd2, seq(1), 1'b0);
    vec(2'd3, seq(1), 1'b1);

    // chain0 PASS/ALONG_M with wrap-around sums
    send(8'd1, 8'd0); send(8'd1, 8'd0); send(8'd1, 8'd2);
    vec(2'd0, {N{32'h7FFFFFFF}}, 1'b0);

    // fill remaining 9 slots, then the 13th byte lands in chain0 op while
    // a chain0 vector is accepted in the same cycle (sees old firmware)
    foreach (bytes_c[i]) send(8'd1, bytes_c[i]);
    configId = 8'd1; configData = 8'd1;
    vec(2'd0, seq(1), 1'b0);
    send(8'd2, 8'h55); send(8'd2, 8'h02); send(8'd2, 8'h00);
    send(8'd1, 8'd5);                 // chain0 addr 5 -> entry 1
    vec(2'd0, seq(-3), 1'b0);         // MASK / ALONG_M, signed compare

    // FUVRF write + read of the same entry in one cycle returns old data
    fuvrf_we = 1; fuvrf_addr = 1; fuvrf_data = {-32'sd1, -32'sd2, -32'sd3, -32'sd4};
    vec(2'd1, seq(-6), 1'b1);
    vec(2'd1, seq(-6), 1'b0);
    tick(); tick();

    // back-to-back stream, tracing low on 4, reset on 8
    for (int i = 0; i < 10; i++) begin
      vec_t x;
      for (int n = 0; n < N; n++) x[n] = $urandom();
      tracing = (i != 4);
      reset   = (i == 8);
      vec(2'(i % 4), x, (i % 3) == 0);
    end
    tracing = 1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
